// File: rtl/sorter_pkg.sv
// Shared types and record-layout helpers for the sorting network back end.
// A record is packed as {dest, user, data} with data in the LSBs.
package sorter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } serializer_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_USER_WIDTH = 32;
    localparam int DEF_DEST_WIDTH = 32;
    localparam int DATA_OFS       = 0;

    function automatic int rec_width(input int dw, input int uw, input int tw);
        return dw + uw + tw;
    endfunction

    function automatic int user_ofs(input int dw);
        return DATA_OFS + dw;
    endfunction

    function automatic int dest_ofs(input int dw, input int uw);
        return DATA_OFS + dw + uw;
    endfunction

endpackage

// File: rtl/sorter_output_serializer.sv
// Replays one captured sorted batch as an AXI-stream, one record per handshake.
// Build option SORTER_SERIALIZER_DESCENDING_EN emits index len-1 down to 0.
module sorter_output_serializer
    import sorter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int USER_WIDTH = DEF_USER_WIDTH,
    parameter int DEST_WIDTH = DEF_DEST_WIDTH,
    parameter int N_ELEMENTS = 8,
    localparam int REC_W = rec_width(DATA_WIDTH, USER_WIDTH, DEST_WIDTH),
    localparam int LEN_W = $clog2(N_ELEMENTS + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                batch_valid,
    output logic                                batch_ready,
    input  logic [N_ELEMENTS-1:0][REC_W-1:0]    batch_data,
    input  logic [LEN_W-1:0]                    batch_length,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [USER_WIDTH-1:0]               out_user,
    output logic [DEST_WIDTH-1:0]               out_dest,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last
);

    localparam int IDX_W    = $clog2(N_ELEMENTS);
    localparam int USER_OFS = user_ofs(DATA_WIDTH);
    localparam int DEST_OFS = dest_ofs(DATA_WIDTH, USER_WIDTH);

    serializer_state_t                  r_state;
    serializer_state_t                  w_state_nxt;
    logic [N_ELEMENTS-1:0][REC_W-1:0]   r_mem;
    logic [LEN_W-1:0]                   r_len;
    logic [IDX_W-1:0]                   r_idx;
    logic                               r_ready;
    logic                               r_valid;
    logic                               r_last;
    logic [DATA_WIDTH-1:0]              r_data;
    logic [USER_WIDTH-1:0]              r_user;
    logic [DEST_WIDTH-1:0]              r_dest;

    logic [LEN_W-1:0]                   w_len_c;
    logic [IDX_W-1:0]                   w_start;
    logic [IDX_W-1:0]                   w_step;
    logic                               w_capture;
    logic                               w_advance;
    logic                               w_done;
    logic [IDX_W-1:0]                   w_sel_idx;
    logic [REC_W-1:0]                   w_sel_rec;
    logic [LEN_W-1:0]                   w_sel_len;
    logic                               w_sel_last;

    // Oversized lengths are clamped to the array depth.
    assign w_len_c = (batch_length > LEN_W'(N_ELEMENTS)) ? LEN_W'(N_ELEMENTS) : batch_length;

`ifdef SORTER_SERIALIZER_DESCENDING_EN
    assign w_start = IDX_W'(w_len_c - LEN_W'(1));
    assign w_step  = r_idx - IDX_W'(1);
`else
    assign w_start = '0;
    assign w_step  = r_idx + IDX_W'(1);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // A zero-length beat is consumed without leaving IDLE.
                if (batch_valid && r_ready && (w_len_c != '0)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (r_valid && out_ready) begin
                    if (r_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_advance   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_sel_idx = w_step;
        w_sel_rec = r_mem[w_step];
        w_sel_len = r_len;
        if (w_capture) begin
            w_sel_idx = w_start;
            w_sel_rec = batch_data[w_start];
            w_sel_len = w_len_c;
        end
`ifdef SORTER_SERIALIZER_DESCENDING_EN
        w_sel_last = (w_sel_idx == '0);
`else
        w_sel_last = (LEN_W'(w_sel_idx) == (w_sel_len - LEN_W'(1)));
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_mem   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == IDLE);
            if (w_capture) begin
                r_mem <= batch_data;
                r_len <= w_len_c;
            end
            if (w_capture || w_advance) begin
                // Output registers are loaded with the record the index is moving to.
                r_idx   <= w_sel_idx;
                r_valid <= 1'b1;
                r_last  <= w_sel_last;
                r_data  <= w_sel_rec[DATA_OFS +: DATA_WIDTH];
                r_user  <= w_sel_rec[USER_OFS +: USER_WIDTH];
                r_dest  <= w_sel_rec[DEST_OFS +: DEST_WIDTH];
            end else if (w_done) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_data  <= '0;
                r_user  <= '0;
                r_dest  <= '0;
            end
        end
    end

    assign batch_ready = r_ready;
    assign out_valid   = r_valid;
    assign out_last    = r_last;
    assign out_data    = r_data;
    assign out_user    = r_user;
    assign out_dest    = r_dest;

endmodule
